// File: rtl/fp_mul_operand_queue.sv
// Operand FIFO in front of a combinational FP multiplier, with a registered
// result stage on its own valid/ready handshake and a retired-product counter.
module fp_mul_operand_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [31:0]       mul_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_c,
    output logic [ADDR_W:0]   occupancy,
    output logic [CNT_W-1:0]  done_cnt
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    pair_t             mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              empty, slot_free, push, pop;

    // in_ready depends on registered occupancy only, so a full queue refuses
    // a push even in a cycle where the head is being popped.
    assign empty     = (occupancy == '0);
    assign in_ready  = (occupancy != (ADDR_W+1)'(DEPTH));
    assign slot_free = ~out_valid | out_ready;
    assign push      = in_valid & in_ready;
    assign pop       = ~empty & slot_free;

    assign mul_a = empty ? 32'h0 : mem[rd_ptr].a;
    assign mul_b = empty ? 32'h0 : mem[rd_ptr].b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            done_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            occupancy <= occupancy + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            // mul_c is combinational in the current head, so it is captured on pop.
            if (pop) begin
                out_c     <= mul_c;
                out_valid <= 1'b1;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: in_a, b: in_b};
    end

endmodule

// File: tb/tb_fp_mul_operand_queue.sv
// Bench for fp_mul_operand_queue: fixed vectors, hand-written stall/full/reset
// sequences, and random traffic against a queue-level reference model.
module tb_fp_mul_operand_queue;
    localparam int DEPTH = 4, ADDR_W = 2, CNT_W = 4;

    logic clk = 0, reset = 0;
    logic in_valid = 0, out_ready = 0;
    logic [31:0] in_a = 0, in_b = 0;
    logic in_ready, out_valid;
    logic [31:0] mul_a, mul_b, mul_c, out_c;
    logic [ADDR_W:0] occupancy;
    logic [CNT_W-1:0] done_cnt;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    // Stand-in multiplier: normal numbers only, truncating.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic s; int e; logic [47:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 0 || b[30:23] == 0) return {s, 31'b0};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        if (m[47]) return {s, 8'(e + 1), m[46:24]};
        return {s, 8'(e), m[45:23]};
    endfunction

    assign mul_c = fmul(mul_a, mul_b);

    fp_mul_operand_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .occupancy(occupancy), .done_cnt(done_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of pending pairs plus the result slot.
    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    pair_t q[$];
    logic        m_vld;
    logic [31:0] m_c;
    int          m_cnt, m_retired;

    task automatic model_clear();
        q.delete(); m_vld = 0; m_c = 0; m_cnt = 0; m_retired = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".out_c"},     out_c,          m_c);
        chk({tag, ".done_cnt"},  32'(done_cnt),  32'(m_cnt % (1 << CNT_W)));
        chk({tag, ".mul_a"},     mul_a,          q.size() != 0 ? q[0].a : 32'h0);
        chk({tag, ".mul_b"},     mul_b,          q.size() != 0 ? q[0].b : 32'h0);
    endtask

    // One cycle: drive, compare against model, clock, advance model.
    task automatic step(input string tag, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic rdy);
        bit do_push, do_pop, free;
        pair_t p;
        in_valid = v; in_a = a; in_b = b; out_ready = rdy;
        #1;
        check_model(tag);
        free    = !m_vld || rdy;
        do_push = v && (q.size() != DEPTH);
        do_pop  = (q.size() != 0) && free;
        @(posedge clk); #1;
        if (m_vld && rdy) begin m_cnt++; m_retired++; end
        if (do_pop) begin p = q.pop_front(); m_c = fmul(p.a, p.b); m_vld = 1; end
        else if (free) m_vld = 0;
        if (do_push) q.push_back('{a: a, b: b});
    endtask

    task automatic do_reset();
        reset = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        model_clear();
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    typedef struct {
        logic v; logic [31:0] a, b; logic rdy;
        logic e_vld; logic [31:0] e_c; int e_occ; int e_cnt;
    } vec_t;

    initial begin
        vec_t vt[6];
        vt[0] = '{1, 32'h3F800000, 32'h40000000, 1, 0, 32'h00000000, 1, 0};
        vt[1] = '{0, 32'h0,        32'h0,        1, 1, 32'h40000000, 0, 0};
        vt[2] = '{1, 32'h3FC00000, 32'h3FC00000, 1, 0, 32'h40000000, 1, 1};
        vt[3] = '{1, 32'hC0000000, 32'h40400000, 1, 1, 32'h40100000, 1, 1};
        vt[4] = '{0, 32'h0,        32'h0,        1, 1, 32'hC0C00000, 0, 2};
        vt[5] = '{0, 32'h0,        32'h0,        1, 0, 32'hC0C00000, 0, 3};

        do_reset();
        #1;
        chk("rst.occupancy", 32'(occupancy), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_c", out_c, 0);
        chk("rst.done_cnt", 32'(done_cnt), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.mul_a", mul_a, 0);

        foreach (vt[i]) begin
            in_valid = vt[i].v; in_a = vt[i].a; in_b = vt[i].b; out_ready = vt[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_vld));
            chk($sformatf("vec%0d.out_c", i), out_c, vt[i].e_c);
            chk($sformatf("vec%0d.occupancy", i), 32'(occupancy), 32'(vt[i].e_occ));
            chk($sformatf("vec%0d.done_cnt", i), 32'(done_cnt), 32'(vt[i].e_cnt));
        end

        // Stall: out_ready low while pushing until the queue is full.
        do_reset();
        for (int i = 0; i < 6; i++)
            step($sformatf("stall%0d", i), 1, 32'h3F800000 + (i << 20), 32'h40000000, 0);
        chk("stall.occupancy", 32'(occupancy), DEPTH);
        chk("stall.in_ready", 32'(in_ready), 0);
        chk("stall.out_c_held", out_c, fmul(32'h3F800000, 32'h40000000));
        chk("stall.out_valid", 32'(out_valid), 1);

        // Full queue: pop with a push offered in the same cycle; push refused.
        step("full_pop", 1, 32'h41000000, 32'h41000000, 1);
        chk("full_pop.occupancy", 32'(occupancy), DEPTH - 1);
        chk("full_pop.in_ready", 32'(in_ready), 1);
        step("full_retry", 1, 32'h41000000, 32'h41000000, 0);
        chk("full_retry.occupancy", 32'(occupancy), DEPTH);
        step("drain1", 0, 0, 0, 1);
        chk("mid.occupancy_pre", 32'(occupancy), 3);

        // Reset mid-stream with occupancy 3 and a pending result.
        reset = 0; #1;
        chk("midrst.occupancy", 32'(occupancy), 0);
        chk("midrst.out_valid", 32'(out_valid), 0);
        chk("midrst.out_c", out_c, 0);
        chk("midrst.done_cnt", 32'(done_cnt), 0);
        do_reset();

        // 16 pairs at full rate: counter wraps back to 0, order preserved.
        for (int i = 0; i < 16; i++) step($sformatf("wrap%0d", i), 1, rnd_fp(), rnd_fp(), 1);
        for (int i = 0; i < 3; i++) step($sformatf("wrapd%0d", i), 0, 0, 0, 1);
        chk("wrap.retired", 32'(m_retired), 16);
        chk("wrap.done_cnt", 32'(done_cnt), 0);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), rnd_fp(), rnd_fp(),
                 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 8; i++) step("rand_drain", 0, 0, 0, 1);
        chk("rand.empty", 32'(occupancy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
